// File: rtl/alu_stream_engine.sv
`default_nettype none
// ============================================================================
// Module      : alu_stream_engine
// Description : Byte-stream ALU command engine. Parses framed commands from an
//               8-bit AXI-stream slave, folds little-endian operands (add, mul,
//               and, or, xor) or runs a sequential signed divide, and streams
//               result bytes LSB first on an 8-bit AXI-stream master. Rejected
//               packets are drained and answered with a single error byte.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_stream_engine #(
    parameter int         OperandWidth = 32,
    parameter logic [7:0] ErrByte      = 8'hEE
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] s_axis_tdata_i,
    input  logic       s_axis_tvalid_i,
    output logic       s_axis_tready_o,
    output logic [7:0] m_axis_tdata_o,
    output logic       m_axis_tvalid_o,
    input  logic       m_axis_tready_i,
    output logic       busy_o,
    output logic       err_o
);

    localparam int                c_OB        = OperandWidth / 8;
    localparam logic [15:0]       c_OB16      = 16'(c_OB);
    localparam logic [15:0]       c_OB_MASK   = 16'(c_OB - 1);
    localparam logic [15:0]       c_MIN_LEN   = 16'(4 + 2 * c_OB);
    localparam logic [7:0]        c_RESP_ONE  = 8'(c_OB);
    localparam logic [7:0]        c_RESP_TWO  = 8'(2 * c_OB);
    localparam int                c_DCW       = $clog2(OperandWidth) + 1;
    localparam logic [c_DCW-1:0]  c_DIV_STEPS = c_DCW'(OperandWidth);

    localparam logic [7:0] c_OP_ADD = 8'hAD;
    localparam logic [7:0] c_OP_MUL = 8'h63;
    localparam logic [7:0] c_OP_DIV = 8'h5B;
    localparam logic [7:0] c_OP_AND = 8'hA1;
    localparam logic [7:0] c_OP_OR  = 8'hA2;
    localparam logic [7:0] c_OP_XOR = 8'hA3;

    localparam logic [2:0] c_S_HDR   = 3'd0;
    localparam logic [2:0] c_S_OPND  = 3'd1;
    localparam logic [2:0] c_S_DIV   = 3'd2;
    localparam logic [2:0] c_S_RESP  = 3'd3;
    localparam logic [2:0] c_S_DRAIN = 3'd4;
    localparam logic [2:0] c_S_ERR   = 3'd5;

    function automatic logic [OperandWidth-1:0] f_neg(input logic [OperandWidth-1:0] x);
        return {OperandWidth{1'b0}} - x;
    endfunction

    function automatic logic [OperandWidth-1:0] f_abs(input logic [OperandWidth-1:0] x);
        return x[OperandWidth-1] ? f_neg(x) : x;
    endfunction

    logic [2:0]                r_state;
    logic [2:0]                w_state_nxt;
    logic [15:0]               r_cnt;
    logic [15:0]               r_len;
    logic [7:0]                r_opcode;
    logic                      r_b1_bad;
    logic [OperandWidth-1:0]   r_opnd;
    logic [OperandWidth-1:0]   r_acc;
    logic [OperandWidth-1:0]   r_quot;
    logic [OperandWidth-1:0]   r_rem;
    logic [OperandWidth-1:0]   r_dvs;
    logic [c_DCW-1:0]          r_dcnt;
    logic                      r_q_neg;
    logic                      r_r_neg;
    logic                      r_dvs_zero;
    logic [2*OperandWidth-1:0] r_res;
    logic [7:0]                r_resp_left;
    logic                      r_s_tready;
    logic                      r_m_tvalid;
    logic [7:0]                r_m_tdata;
    logic                      r_err;

    logic                      w_s_fire;
    logic                      w_m_fire;
    logic                      w_last_pkt_byte;
    logic [15:0]               w_pay;
    logic                      w_op_last;
    logic                      w_op_first;
    logic                      w_is_div;
    logic [15:0]               w_len_full;
    logic                      w_op_known;
    logic                      w_hdr_bad;
    logic [OperandWidth+7:0]   w_shift;
    logic [OperandWidth-1:0]   w_opnd_full;
    logic [OperandWidth-1:0]   w_fold;
    logic [OperandWidth:0]     w_div_sh;
    logic                      w_div_ge;
    logic [OperandWidth-1:0]   w_div_sub;
    logic [OperandWidth-1:0]   w_q_fix;
    logic [OperandWidth-1:0]   w_r_fix;

    assign w_s_fire        = r_s_tready & s_axis_tvalid_i;
    assign w_m_fire        = r_m_tvalid & m_axis_tready_i;
    assign w_last_pkt_byte = (r_cnt == (r_len - 16'd1));
    assign w_pay           = r_cnt - 16'd4;
    assign w_op_last       = ((w_pay & c_OB_MASK) == c_OB_MASK);
    assign w_op_first      = (w_pay < c_OB16);
    assign w_is_div        = (r_opcode == c_OP_DIV);

    // Header validation happens while LEN[15:8] is on the bus.
    assign w_len_full = {s_axis_tdata_i, r_len[7:0]};
    assign w_op_known = (r_opcode == c_OP_ADD) || (r_opcode == c_OP_MUL) ||
                        (r_opcode == c_OP_DIV) || (r_opcode == c_OP_AND) ||
                        (r_opcode == c_OP_OR)  || (r_opcode == c_OP_XOR);
    assign w_hdr_bad  = !w_op_known || r_b1_bad ||
                        (((w_len_full - 16'd4) & c_OB_MASK) != 16'd0) ||
                        (w_len_full < c_MIN_LEN) ||
                        (w_is_div && (w_len_full != c_MIN_LEN));

    // Operand bytes arrive LSB first, so each new byte enters at the top.
    assign w_shift     = {s_axis_tdata_i, r_opnd};
    assign w_opnd_full = w_shift[OperandWidth+7:8];

    // Restoring divide step on magnitudes; remainder never exceeds the divisor.
    assign w_div_sh  = {r_rem, r_quot[OperandWidth-1]};
    assign w_div_ge  = (w_div_sh >= {1'b0, r_dvs});
    assign w_div_sub = w_div_sh[OperandWidth-1:0] - r_dvs;
    assign w_q_fix   = r_dvs_zero ? {OperandWidth{1'b1}} : (r_q_neg ? f_neg(r_quot) : r_quot);
    assign w_r_fix   = r_r_neg ? f_neg(r_rem) : r_rem;

    // Combine the running accumulator with the operand completing this cycle.
    always_comb begin
        w_fold = r_acc;
        case (r_opcode)
            c_OP_ADD: w_fold = r_acc + w_opnd_full;
            c_OP_MUL: w_fold = r_acc * w_opnd_full;
            c_OP_AND: w_fold = r_acc & w_opnd_full;
            c_OP_OR:  w_fold = r_acc | w_opnd_full;
            c_OP_XOR: w_fold = r_acc ^ w_opnd_full;
            default:  w_fold = r_acc;
        endcase
    end

    // Next-state selection for the packet-level controller.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_HDR: begin
                if (w_s_fire && (r_cnt == 16'd3)) begin
                    if (w_hdr_bad) begin
                        w_state_nxt = (w_len_full <= 16'd4) ? c_S_ERR : c_S_DRAIN;
                    end else begin
                        w_state_nxt = c_S_OPND;
                    end
                end
            end
            c_S_OPND: begin
                if (w_s_fire && w_op_last && w_last_pkt_byte) begin
                    w_state_nxt = w_is_div ? c_S_DIV : c_S_RESP;
                end
            end
            c_S_DIV: begin
                if (r_dcnt == c_DIV_STEPS) begin
                    w_state_nxt = c_S_RESP;
                end
            end
            c_S_RESP: begin
                if (w_m_fire && (r_resp_left == 8'd0)) begin
                    w_state_nxt = c_S_HDR;
                end
            end
            c_S_DRAIN: begin
                if (w_s_fire && w_last_pkt_byte) begin
                    w_state_nxt = c_S_ERR;
                end
            end
            c_S_ERR: begin
                if (w_m_fire) begin
                    w_state_nxt = c_S_HDR;
                end
            end
            default: w_state_nxt = c_S_HDR;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= c_S_HDR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: header capture, operand folding, divider and response streaming.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cnt       <= '0;
            r_len       <= '0;
            r_opcode    <= '0;
            r_b1_bad    <= 1'b0;
            r_opnd      <= '0;
            r_acc       <= '0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_dvs       <= '0;
            r_dcnt      <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_dvs_zero  <= 1'b0;
            r_res       <= '0;
            r_resp_left <= '0;
            r_s_tready  <= 1'b0;
            r_m_tvalid  <= 1'b0;
            r_m_tdata   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_s_tready <= (w_state_nxt == c_S_HDR) || (w_state_nxt == c_S_OPND) ||
                          (w_state_nxt == c_S_DRAIN);
            r_err      <= 1'b0;
            case (r_state)
                c_S_HDR: begin
                    if (w_s_fire) begin
                        r_cnt <= r_cnt + 16'd1;
                        case (r_cnt)
                            16'd0:   r_opcode   <= s_axis_tdata_i;
                            16'd1:   r_b1_bad   <= (s_axis_tdata_i != 8'h00);
                            16'd2:   r_len[7:0] <= s_axis_tdata_i;
                            default: r_len[15:8] <= s_axis_tdata_i;
                        endcase
                    end
                end
                c_S_OPND: begin
                    if (w_s_fire) begin
                        r_cnt  <= r_cnt + 16'd1;
                        r_opnd <= w_opnd_full;
                        if (w_op_last) begin
                            if (w_op_first) begin
                                r_acc <= w_opnd_full;
                            end else if (w_is_div) begin
                                r_quot     <= f_abs(r_acc);
                                r_dvs      <= f_abs(w_opnd_full);
                                r_rem      <= '0;
                                r_dcnt     <= '0;
                                r_q_neg    <= r_acc[OperandWidth-1] ^ w_opnd_full[OperandWidth-1];
                                r_r_neg    <= r_acc[OperandWidth-1];
                                r_dvs_zero <= (w_opnd_full == '0);
                            end else begin
                                r_acc <= w_fold;
                                if (w_last_pkt_byte) begin
                                    r_res       <= {{OperandWidth{1'b0}}, w_fold};
                                    r_resp_left <= c_RESP_ONE;
                                end
                            end
                        end
                    end
                end
                c_S_DIV: begin
                    if (r_dcnt != c_DIV_STEPS) begin
                        r_rem  <= w_div_ge ? w_div_sub : w_div_sh[OperandWidth-1:0];
                        r_quot <= {r_quot[OperandWidth-2:0], w_div_ge};
                        r_dcnt <= r_dcnt + 1'b1;
                    end else begin
                        r_res       <= {w_r_fix, w_q_fix};
                        r_resp_left <= c_RESP_TWO;
                    end
                end
                c_S_RESP: begin
                    if (!r_m_tvalid || (w_m_fire && (r_resp_left != 8'd0))) begin
                        r_m_tdata   <= r_res[7:0];
                        r_m_tvalid  <= 1'b1;
                        r_res       <= r_res >> 8;
                        r_resp_left <= r_resp_left - 8'd1;
                    end else if (w_m_fire) begin
                        r_m_tvalid <= 1'b0;
                        r_cnt      <= '0;
                    end
                end
                c_S_DRAIN: begin
                    if (w_s_fire) begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                c_S_ERR: begin
                    if (!r_m_tvalid) begin
                        r_m_tdata  <= ErrByte;
                        r_m_tvalid <= 1'b1;
                        r_err      <= 1'b1;
                    end else if (w_m_fire) begin
                        r_m_tvalid <= 1'b0;
                        r_cnt      <= '0;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign s_axis_tready_o = r_s_tready;
    assign m_axis_tvalid_o = r_m_tvalid;
    assign m_axis_tdata_o  = r_m_tdata;
    assign err_o           = r_err;
    assign busy_o          = !((r_state == c_S_HDR) && (r_cnt == 16'd0));

endmodule
`default_nettype wire

// File: tb/tb_alu_stream_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_stream_engine
// Description : Directed self-checking bench for alu_stream_engine with a
//               behavioural response model and per-cycle output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_stream_engine;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic [7:0] s_tdata = 8'h00;
    logic       s_tvalid = 1'b0;
    logic       s_tready;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready = 1'b1;
    logic       busy;
    logic       err;

    alu_stream_engine dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .s_axis_tdata_i (s_tdata),
        .s_axis_tvalid_i(s_tvalid),
        .s_axis_tready_o(s_tready),
        .m_axis_tdata_o (m_tdata),
        .m_axis_tvalid_o(m_tvalid),
        .m_axis_tready_i(m_tready),
        .busy_o         (busy),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int acc_cyc = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  cap_q[$];
    logic [31:0] ops_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Expected response bytes straight from the arithmetic definition of each opcode.
    task automatic push_model(input logic [7:0] op, input bit ok);
        logic [31:0] r;
        logic [31:0] q;
        logic [31:0] rm;
        logic [31:0] a;
        logic [31:0] b;
        if (!ok) begin
            exp_q.push_back(8'hEE);
            return;
        end
        if (op == 8'h5B) begin
            a = ops_q[0];
            b = ops_q[1];
            if (b == 32'd0) begin
                q = 32'hFFFF_FFFF; rm = a;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a; rm = 32'd0;
            end else begin
                q  = $signed(a) / $signed(b);
                rm = $signed(a) % $signed(b);
            end
            for (int i = 0; i < 4; i++) exp_q.push_back(q[8*i +: 8]);
            for (int i = 0; i < 4; i++) exp_q.push_back(rm[8*i +: 8]);
        end else begin
            r = ops_q[0];
            for (int i = 1; i < ops_q.size(); i++) begin
                case (op)
                    8'hAD:   r = r + ops_q[i];
                    8'h63:   r = r * ops_q[i];
                    8'hA1:   r = r & ops_q[i];
                    8'hA2:   r = r | ops_q[i];
                    default: r = r ^ ops_q[i];
                endcase
            end
            for (int i = 0; i < 4; i++) exp_q.push_back(r[8*i +: 8]);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        s_tdata  = b;
        s_tvalid = 1'b1;
        while (!s_tready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!s_tready) begin
            checks++; errors++;
            $display("FAIL send_timeout: got tready=0 expected tready=1");
        end else begin
            @(negedge clk);
        end
        s_tvalid = 1'b0;
    endtask

    task automatic send_packet(input logic [7:0] op, input logic [7:0] b1,
                               input logic [15:0] len, input bit ok);
        logic [31:0] w;
        cap_q.delete();
        push_model(op, ok);
        send_byte(op);
        send_byte(b1);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
        for (int i = 0; i < ops_q.size(); i++) begin
            w = ops_q[i];
            for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
        end
        acc_cyc = cyc;
    endtask

    task automatic wait_first_valid(output int lat);
        int n = 0;
        while (!m_tvalid && n < 200) begin
            @(negedge clk);
            n++;
        end
        lat = m_tvalid ? (cyc - acc_cyc) : -1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d bytes pending expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [31:0] cap_word(input int n);
        logic [31:0] w = 32'h0;
        for (int i = 0; i < 4; i++)
            if (4*n + i < cap_q.size()) w[8*i +: 8] = cap_q[4*n + i];
        return w;
    endfunction

    // Per-cycle output monitor: scoreboard, hold-under-stall and input-stall checks.
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [7:0] pd = 8'h00;
    always @(negedge clk) begin
        if (reset_i) begin
            pv = 1'b0;
        end else begin
            if (err) err_pulses++;
            if (pv && !pr) begin
                chk("hold_valid", 64'(m_tvalid), 64'd1);
                chk("hold_data", 64'(m_tdata), 64'(pd));
            end
            if (m_tvalid) chk("input_stalled", 64'(s_tready), 64'd0);
            if (m_tvalid && m_tready) begin
                cap_q.push_back(m_tdata);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", m_tdata);
                end else begin
                    chk("resp_byte", 64'(m_tdata), 64'(exp_q.pop_front()));
                end
            end
            pv = m_tvalid;
            pr = m_tready;
            pd = m_tdata;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int base;
        logic [7:0] d0;

        repeat (3) @(negedge clk);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tdata", 64'(m_tdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        reset_i = 1'b0;
        @(negedge clk);
        chk("tready_after_reset", 64'(s_tready), 64'd1);

        // Add with wrap-around
        base = err_pulses;
        ops_q = '{32'h1, 32'h2, 32'hFFFF_FFFF};
        send_packet(8'hAD, 8'h00, 16'h0010, 1'b1);
        wait_first_valid(lat);
        chk("add_latency", 64'(lat), 64'd1);
        wait_drain();
        chk("add_count", 64'(cap_q.size()), 64'd4);
        chk("add_result", 64'(cap_word(0)), 64'h0000_0002);
        chk("add_no_err", 64'(err_pulses - base), 64'd0);

        // Multiply (low bits) and XOR
        ops_q = '{32'h7, 32'hFFFF_FFFD};
        send_packet(8'h63, 8'h00, 16'h000C, 1'b1);
        wait_drain();
        chk("mul_result", 64'(cap_word(0)), 64'hFFFF_FFEB);
        ops_q = '{32'hF0F0_F0F0, 32'hFFFF_0000};
        send_packet(8'hA3, 8'h00, 16'h000C, 1'b1);
        wait_drain();
        chk("xor_result", 64'(cap_word(0)), 64'h0F0F_F0F0);
        ops_q = '{32'h1234_0000, 32'h0000_5678};
        send_packet(8'hA2, 8'h00, 16'h000C, 1'b1);
        wait_drain();
        chk("or_result", 64'(cap_word(0)), 64'h1234_5678);

        // Signed divide
        ops_q = '{32'hFFFF_FFF9, 32'h2};
        send_packet(8'h5B, 8'h00, 16'h000C, 1'b1);
        wait_first_valid(lat);
        chk("div_latency", 64'(lat), 64'd34);
        wait_drain();
        chk("div_count", 64'(cap_q.size()), 64'd8);
        chk("div_quot", 64'(cap_word(0)), 64'hFFFF_FFFD);
        chk("div_rem", 64'(cap_word(1)), 64'hFFFF_FFFF);

        // Divide by zero
        ops_q = '{32'hA, 32'h0};
        send_packet(8'h5B, 8'h00, 16'h000C, 1'b1);
        wait_first_valid(lat);
        chk("div0_latency", 64'(lat), 64'd34);
        wait_drain();
        chk("div0_quot", 64'(cap_word(0)), 64'hFFFF_FFFF);
        chk("div0_rem", 64'(cap_word(1)), 64'h0000_000A);

        // Unknown opcode: drain 8 bytes, one error pulse, EE response
        base = err_pulses;
        ops_q = '{32'h1122_3344, 32'h5566_7788};
        send_packet(8'h77, 8'h00, 16'h000C, 1'b0);
        wait_drain();
        chk("err_count", 64'(cap_q.size()), 64'd1);
        chk("err_byte", 64'(cap_word(0)), 64'h0000_00EE);
        chk("err_pulse_once", 64'(err_pulses - base), 64'd1);
        chk("idle_after_err", 64'(busy), 64'd0);
        ops_q = '{32'h5, 32'h6};
        send_packet(8'hAD, 8'h00, 16'h000C, 1'b1);
        wait_drain();
        chk("recover_add", 64'(cap_word(0)), 64'h0000_000B);

        // Other rejects: nonzero byte1, LEN<=4 (no payload), div with 3 operands
        ops_q = '{32'h1, 32'h2};
        send_packet(8'hAD, 8'h01, 16'h000C, 1'b0);
        wait_drain();
        chk("b1_reject", 64'(cap_word(0)), 64'h0000_00EE);
        ops_q.delete();
        send_packet(8'hAD, 8'h00, 16'h0004, 1'b0);
        wait_drain();
        chk("short_reject", 64'(cap_word(0)), 64'h0000_00EE);
        ops_q = '{32'h9, 32'h3, 32'h1};
        send_packet(8'h5B, 8'h00, 16'h0010, 1'b0);
        wait_drain();
        chk("div_len_reject", 64'(cap_word(0)), 64'h0000_00EE);

        // MIN / -1 under 20 cycles of output backpressure
        m_tready = 1'b0;
        ops_q = '{32'h8000_0000, 32'hFFFF_FFFF};
        send_packet(8'h5B, 8'h00, 16'h000C, 1'b1);
        wait_first_valid(lat);
        chk("stall_latency", 64'(lat), 64'd34);
        d0 = m_tdata;
        repeat (20) @(negedge clk);
        chk("stall_valid", 64'(m_tvalid), 64'd1);
        chk("stall_data", 64'(m_tdata), 64'(d0));
        m_tready = 1'b1;
        wait_drain();
        chk("minneg1_count", 64'(cap_q.size()), 64'd8);
        chk("minneg1_quot", 64'(cap_word(0)), 64'h8000_0000);
        chk("minneg1_rem", 64'(cap_word(1)), 64'h0000_0000);

        // Reset in the middle of an operand
        cap_q.delete();
        send_byte(8'hAD); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        reset_i = 1'b1;
        @(negedge clk);
        chk("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("mid_rst_tready", 64'(s_tready), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        chk("mid_rst_tready_up", 64'(s_tready), 64'd1);
        ops_q = '{32'hFF00_FF00, 32'h0F0F_0F0F, 32'hFFFF_FFF0};
        send_packet(8'hA1, 8'h00, 16'h0010, 1'b1);
        wait_drain();
        chk("and_after_reset", 64'(cap_word(0)), 64'h0F00_0F00);
        chk("no_partial_resp", 64'(cap_q.size()), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_stream_engine.md
Name: alu_stream_engine

Overview:
Parametrised successor of the UART ALU command core. It consumes a framed command byte stream from the UART receiver on an 8-bit AXI-stream slave and produces result bytes on an 8-bit AXI-stream master toward the UART transmitter. Compared with the current core it adds:
- configurable operand width
- bitwise opcodes
- a sequential signed divider
- explicit error framing with payload drain

Parameters:
OperandWidth, 32, operand/result width in bits; legal values 8, 16, 32, 64; OB = OperandWidth/8
ErrByte, 8'hEE, single-byte response for rejected packets

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
s_axis_tdata_i  in  8  command byte
s_axis_tvalid_i  in  1  command byte valid
s_axis_tready_o  out  1  engine accepts byte
m_axis_tdata_o  out  8  response byte
m_axis_tvalid_o  out  1  response byte valid
m_axis_tready_i  in  1  downstream accepts byte
busy_o  out  1  high in any state other than HDR with byte count 0
err_o  out  1  one-cycle pulse when a packet is rejected

Behaviour:
- Interface: one clock, clk_i; reset_i is synchronous and active-high. All state updates on the rising edge of clk_i.
- Reset values: state=HDR, counters 0, accumulator 0, s_axis_tready_o=0, m_axis_tvalid_o=0, m_axis_tdata_o=0, busy_o=0, err_o=0.
- s_axis_tready_o rises 1 cycle after reset_i falls.
- Reset asserted mid-packet aborts everything. No partial response is sent.
- Transfers: a byte transfers when tvalid&&tready on a clock edge. m_axis_tdata_o/m_axis_tvalid_o are registered and hold stable until accepted.
- Packet format: byte0 opcode, byte1 0x00, byte2 LEN[7:0], byte3 LEN[15:8]. LEN counts header plus payload. Payload is operands, OB bytes each, little-endian.
- Opcodes:
  - 0xad add: wrapping sum.
  - 0x63 mul: low OperandWidth bits of the running product.
  - 0x5b signed div.
  - 0xa1 AND, 0xa2 OR, 0xa3 XOR.
- Validation on the byte3 edge. Reject if any of:
  - opcode is unknown
  - byte1 != 0
  - (LEN-4) mod OB != 0
  - LEN < 4+2*OB
  - opcode is div and LEN != 4+2*OB
- States:
  - HDR: accept 4 header bytes. Valid packet -> OPND. Invalid -> DRAIN, or directly to ERR if LEN<=4.
  - OPND: tready=1. Shift bytes into an operand register. On the last byte of each operand:
    - first operand loads the accumulator
    - later operands fold (add/mul/and/or/xor) in the same edge
    - div stores dividend, then divisor
    - After the final operand -> RESP (add/mul/logic) or DIV.
  - DIV: tready=0. Restoring division on magnitudes, 1 quotient bit per cycle, OperandWidth cycles, plus 1 sign-fix cycle -> RESP.
    - Quotient truncates toward zero; remainder takes the dividend's sign.
    - Divisor 0: quotient = all ones, remainder = dividend; takes the same cycle count.
    - MIN / -1: quotient = MIN, remainder = 0.
  - RESP: tready=0. Emit result bytes LSB first: OB bytes for add/mul/logic; 2*OB bytes for div (quotient, then remainder). After the last byte is accepted -> HDR; tready=1 on the following cycle.
  - DRAIN: tready=1. Accept and discard LEN-4 bytes -> ERR.
  - ERR: pulse err_o, emit ErrByte once -> HDR after it is accepted.
- Latency:
  - add/mul/logic: first response byte valid 1 cycle after the edge accepting the last operand byte.
  - div: first response byte valid OperandWidth+2 cycles after that edge.
- Backpressure: m_axis_tready_i low holds RESP/ERR indefinitely with data stable. The input stays stalled (tready=0) for the whole period.
- Counters: byte counter is 16 bits; LEN up to 0xFFFF is legal. No internal limit on operand count.

Test Plan (OperandWidth=32):
1. Add: ad 00 10 00, operands 00000001, 00000002, FFFFFFFF -> response 02 00 00 00; err_o never pulses.
2. Mul/XOR:
   - ad-style header with 0x63, LEN 0x000C, operands 00000007, FFFFFFFD -> EB FF FF FF.
   - 0xa3, LEN 0x000C, operands F0F0F0F0, FFFF0000 -> F0 F0 0F 0F.
3. Signed div: 5b 00 0c 00, operands FFFFFFF9 (-7), 00000002 -> FD FF FF FF FF FF FF FF. First byte valid exactly 34 cycles after the last operand byte.
4. Div by zero: operands 0000000A, 00000000 -> FF FF FF FF 0A 00 00 00.
5. Error/recovery: opcode 0x77, LEN 0x000C, 8 payload bytes -> all 8 drained, err_o pulses once, response EE. A following valid add packet returns the correct sum.
6. Backpressure/reset: hold m_axis_tready_i low 20 cycles during a div response -> tdata stable, no byte lost. Assert reset_i mid-operand -> tvalid=0, tready=0 during reset. The next packet is processed correctly.
